// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds the FAULT state).
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    WAIT  = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    FAULT = 3'd4
`endif
  } fetch_state_t;

  // Sequential PC increment; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/acknowledge bus.
// The fetch stage is the master; the memory is the slave.
interface fetch_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry buffer for an instruction that returns while
// the fetch stage is stalled. Drop has priority over load, load over consume.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drop,
  input  logic               consume,
  input  logic [INSTR_W-1:0] din,
  output logic [INSTR_W-1:0] dout,
  output logic               valid
);

  logic [INSTR_W-1:0] data_r;
  logic               valid_r;

  // Capture a stalled return word; forget it on redirect or once it has been used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {INSTR_W{1'b0}};
      valid_r <= 1'b0;
    end else if (drop) begin
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= din;
      valid_r <= 1'b1;
    end else if (consume) begin
      valid_r <= 1'b0;
    end
  end

  assign dout  = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, keeps at most one memory
// request in flight and registers {PC, PC+4, instr} for decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect trap).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stallF,
  input  logic               clrBU,
  input  logic [31:0]        branch_target,
  fetch_if.master            imem,
  output logic [31:0]        PC_fe_output,
  output logic [31:0]        PCInc_fe_output,
  output logic [INSTR_W-1:0] Instr_fe_output,
  output logic               fe_valid,
  output logic               fe_busy
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic               misalign_fault
`endif
);

  fetch_state_t       state_r, state_s;
  logic [31:0]        pc_r, pc_s;
  logic [31:0]        addr_hold_r;
  logic [31:0]        target_s;
  logic               req_s;
  logic               out_load_s, out_clr_s;
  logic [INSTR_W-1:0] out_word_s;
  logic               buf_load_s, buf_drop_s, buf_consume_s;
  logic [INSTR_W-1:0] hold_data_s;
  logic               hold_valid_s;
  logic [31:0]        out_pc_r, out_inc_r;
  logic [INSTR_W-1:0] out_instr_r;
  logic               out_valid_r;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_r, fault_s;
  assign target_s = branch_target;
`else
  // Without the trap, redirects are forced word-aligned.
  assign target_s = branch_target & 32'hFFFF_FFFC;
`endif

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (buf_load_s),
    .drop    (buf_drop_s),
    .consume (buf_consume_s),
    .din     (imem.imem_rdata),
    .dout    (hold_data_s),
    .valid   (hold_valid_s)
  );

  // Next-state, next-PC and output-register controls; redirect outranks everything.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    req_s         = 1'b0;
    out_load_s    = 1'b0;
    out_clr_s     = 1'b0;
    out_word_s    = imem.imem_rdata;
    buf_load_s    = 1'b0;
    buf_drop_s    = 1'b0;
    buf_consume_s = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_s       = fault_r;
`endif

    case (state_r)
      RUN:         req_s = !stallF && !clrBU;
      WAIT, DRAIN: req_s = 1'b1;
      HOLD:        req_s = 1'b0;
      default:     req_s = 1'b0;
    endcase

    if (clrBU) begin
      pc_s       = target_s;
      out_clr_s  = 1'b1;
      buf_drop_s = 1'b1;
      // An unanswered request still belongs to memory: wait it out in DRAIN.
      if ((state_r == WAIT || state_r == DRAIN) && !imem.imem_ack) begin
        state_s = DRAIN;
      end else begin
        state_s = RUN;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (branch_target[1:0] != 2'b00) begin
        state_s = FAULT;
        fault_s = 1'b1;
      end else begin
        fault_s = 1'b0;
      end
`endif
    end else begin
      case (state_r)
        RUN: begin
          if (req_s && imem.imem_ack) begin
            out_load_s = 1'b1;
            pc_s       = pc_next(pc_r);
          end else if (req_s) begin
            state_s = WAIT;
          end else begin
            state_s = RUN;
          end
        end
        WAIT: begin
          if (imem.imem_ack && !stallF) begin
            out_load_s = 1'b1;
            pc_s       = pc_next(pc_r);
            state_s    = RUN;
          end else if (imem.imem_ack) begin
            buf_load_s = 1'b1;
            state_s    = HOLD;
          end else begin
            state_s = WAIT;
          end
        end
        HOLD: begin
          if (!stallF && hold_valid_s) begin
            out_load_s    = 1'b1;
            out_word_s    = hold_data_s;
            buf_consume_s = 1'b1;
            pc_s          = pc_next(pc_r);
            state_s       = RUN;
          end else begin
            state_s = HOLD;
          end
        end
        DRAIN: begin
          if (imem.imem_ack) begin
            state_s = RUN;
          end else begin
            state_s = DRAIN;
          end
        end
        default: state_s = state_r;
      endcase
    end
  end

  // State, PC and (optional) fault flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      pc_r    <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_r <= fault_s;
`endif
    end
  end

  // Remember the in-flight address so DRAIN keeps it stable after the PC is redirected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold_r <= RESET_PC;
    end else if (state_r != DRAIN) begin
      addr_hold_r <= pc_r;
    end
  end

  // Decode-facing output registers: cleared on redirect, loaded on delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc_r    <= 32'h0000_0000;
      out_inc_r   <= 32'h0000_0000;
      out_instr_r <= {INSTR_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (out_clr_s) begin
      out_pc_r    <= 32'h0000_0000;
      out_inc_r   <= 32'h0000_0000;
      out_instr_r <= {INSTR_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (out_load_s) begin
      out_pc_r    <= pc_r;
      out_inc_r   <= pc_next(pc_r);
      out_instr_r <= out_word_s;
      out_valid_r <= 1'b1;
    end
  end

  // No request may leave the stage while reset is held.
  assign imem.imem_req  = req_s && rst_n;
  assign imem.imem_addr = (state_r == DRAIN) ? addr_hold_r : pc_r;

  assign PC_fe_output    = out_pc_r;
  assign PCInc_fe_output = out_inc_r;
  assign Instr_fe_output = out_instr_r;
  assign fe_valid        = out_valid_r;
  assign fe_busy         = (state_r == WAIT) || (state_r == DRAIN);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_fault  = fault_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run against a
// transaction-level model of the fetch stage.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallF;
  logic        clrBU;
  logic [31:0] branch_target;
  logic [31:0] PC_fe_output;
  logic [31:0] PCInc_fe_output;
  logic [31:0] Instr_fe_output;
  logic        fe_valid;
  logic        fe_busy;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_fault;
  localparam logic [31:0] ODD_TGT = 32'h0000_0100;
`else
  localparam logic [31:0] ODD_TGT = 32'h0000_0103;
`endif

  fetch_if imem ();

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stallF          (stallF),
    .clrBU           (clrBU),
    .branch_target   (branch_target),
    .imem            (imem),
    .PC_fe_output    (PC_fe_output),
    .PCInc_fe_output (PCInc_fe_output),
    .Instr_fe_output (Instr_fe_output),
    .fe_valid        (fe_valid),
    .fe_busy         (fe_busy)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_fault  (misalign_fault)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        st;
    logic        cl;
    logic [31:0] tg;
    logic        ak;
    logic [31:0] rd;
    logic        rq;
    logic [31:0] ad;
    logic        bz;
    logic        vl;
    logic [31:0] pc;
    logic [31:0] inc;
    logic [31:0] ins;
  } vec_t;

  function automatic vec_t mk(logic st, logic cl, logic [31:0] tg, logic ak, logic [31:0] rd,
                              logic rq, logic [31:0] ad, logic bz,
                              logic vl, logic [31:0] pc, logic [31:0] ins);
    vec_t v;
    v.st = st; v.cl = cl; v.tg = tg; v.ak = ak; v.rd = rd;
    v.rq = rq; v.ad = ad; v.bz = bz; v.vl = vl; v.pc = pc; v.ins = ins;
    v.inc = vl ? pc + 32'd4 : 32'd0;
    return v;
  endfunction

  vec_t tbl[30];

  task automatic apply_row(input vec_t v, input int idx);
    stallF = v.st; clrBU = v.cl; branch_target = v.tg;
    imem.imem_ack = v.ak; imem.imem_rdata = v.rd;
    #1;
    chk($sformatf("row%0d_req", idx), 32'(imem.imem_req), 32'(v.rq));
    if (v.rq) chk($sformatf("row%0d_addr", idx), imem.imem_addr, v.ad);
    chk($sformatf("row%0d_busy", idx), 32'(fe_busy), 32'(v.bz));
    @(posedge clk); #1;
    chk($sformatf("row%0d_valid", idx), 32'(fe_valid), 32'(v.vl));
    chk($sformatf("row%0d_pc", idx), PC_fe_output, v.pc);
    chk($sformatf("row%0d_pcinc", idx), PCInc_fe_output, v.inc);
    chk($sformatf("row%0d_instr", idx), Instr_fe_output, v.ins);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] m_pc, m_opc, m_oinc, m_oins, m_pend_addr, m_hw;
  logic        m_ovalid, m_pend, m_stale, m_hb;

  task automatic m_reset();
    m_pc = 32'd0; m_opc = 32'd0; m_oinc = 32'd0; m_oins = 32'd0; m_ovalid = 1'b0;
    m_pend = 1'b0; m_pend_addr = 32'd0; m_stale = 1'b0; m_hb = 1'b0; m_hw = 32'd0;
  endtask

  function automatic logic m_req(input logic st, input logic cl);
    if (m_pend) return 1'b1;
    if (m_hb) return 1'b0;
    return !st && !cl;
  endfunction

  task automatic m_deliver(input logic [31:0] w);
    m_opc = m_pc; m_oinc = m_pc + 32'd4; m_oins = w; m_ovalid = 1'b1;
    m_pc = m_pc + 32'd4;
  endtask

  task automatic m_edge(input logic st, input logic cl, input logic [31:0] tg,
                        input logic ak, input logic [31:0] rd);
    logic rq, acc;
    rq  = m_req(st, cl);
    acc = ak && rq;
    if (cl) begin
      m_pc = tg & 32'hFFFF_FFFC;
      m_opc = 32'd0; m_oinc = 32'd0; m_oins = 32'd0; m_ovalid = 1'b0;
      m_hb = 1'b0;
      if (m_pend && !acc) m_stale = 1'b1;
      else m_pend = 1'b0;
    end else if (m_pend) begin
      if (acc) begin
        m_pend = 1'b0;
        if (!m_stale) begin
          if (!st) m_deliver(rd);
          else begin m_hb = 1'b1; m_hw = rd; end
        end
      end
    end else if (m_hb) begin
      if (!st) begin m_deliver(m_hw); m_hb = 1'b0; end
    end else if (rq) begin
      if (acc) m_deliver(rd);
      else begin m_pend = 1'b1; m_pend_addr = m_pc; m_stale = 1'b0; end
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        st, cl, ak, rq;
    logic [31:0] tg, rd, ad;

    rst_n = 1'b0; stallF = 1'b0; clrBU = 1'b0; branch_target = 32'd0;
    imem.imem_ack = 1'b0; imem.imem_rdata = 32'd0;

    tbl[0]  = mk(1'b0,1'b0,32'h0,1'b1,32'h11, 1'b1,32'h0,1'b0, 1'b1,32'h0,32'h11);
    tbl[1]  = mk(1'b0,1'b0,32'h0,1'b1,32'h22, 1'b1,32'h4,1'b0, 1'b1,32'h4,32'h22);
    tbl[2]  = mk(1'b0,1'b0,32'h0,1'b1,32'h33, 1'b1,32'h8,1'b0, 1'b1,32'h8,32'h33);
    tbl[3]  = mk(1'b0,1'b0,32'h0,1'b0,32'h0,  1'b1,32'hC,1'b0, 1'b1,32'h8,32'h33);
    tbl[4]  = mk(1'b0,1'b0,32'h0,1'b0,32'h0,  1'b1,32'hC,1'b1, 1'b1,32'h8,32'h33);
    tbl[5]  = mk(1'b0,1'b0,32'h0,1'b0,32'h0,  1'b1,32'hC,1'b1, 1'b1,32'h8,32'h33);
    tbl[6]  = mk(1'b0,1'b0,32'h0,1'b1,32'h44, 1'b1,32'hC,1'b1, 1'b1,32'hC,32'h44);
    tbl[7]  = mk(1'b0,1'b0,32'h0,1'b0,32'h0,  1'b1,32'h10,1'b0, 1'b1,32'hC,32'h44);
    tbl[8]  = mk(1'b1,1'b0,32'h0,1'b0,32'h0,  1'b1,32'h10,1'b1, 1'b1,32'hC,32'h44);
    tbl[9]  = mk(1'b1,1'b0,32'h0,1'b1,32'h55, 1'b1,32'h10,1'b1, 1'b1,32'hC,32'h44);
    tbl[10] = mk(1'b1,1'b0,32'h0,1'b0,32'h0,  1'b0,32'h0,1'b0,  1'b1,32'hC,32'h44);
    tbl[11] = mk(1'b0,1'b0,32'h0,1'b0,32'h0,  1'b0,32'h0,1'b0,  1'b1,32'h10,32'h55);
    tbl[12] = mk(1'b0,1'b0,32'h0,1'b0,32'h0,  1'b1,32'h14,1'b0, 1'b1,32'h10,32'h55);
    tbl[13] = mk(1'b0,1'b1,32'h100,1'b0,32'h0, 1'b1,32'h14,1'b1, 1'b0,32'h0,32'h0);
    tbl[14] = mk(1'b0,1'b0,32'h0,1'b0,32'h0,  1'b1,32'h14,1'b1, 1'b0,32'h0,32'h0);
    tbl[15] = mk(1'b0,1'b0,32'h0,1'b1,32'h66, 1'b1,32'h14,1'b1, 1'b0,32'h0,32'h0);
    tbl[16] = mk(1'b0,1'b0,32'h0,1'b1,32'h77, 1'b1,32'h100,1'b0, 1'b1,32'h100,32'h77);
    tbl[17] = mk(1'b1,1'b1,32'h200,1'b0,32'h0, 1'b0,32'h0,1'b0, 1'b0,32'h0,32'h0);
    tbl[18] = mk(1'b1,1'b0,32'h0,1'b0,32'h0,  1'b0,32'h0,1'b0,  1'b0,32'h0,32'h0);
    tbl[19] = mk(1'b0,1'b0,32'h0,1'b1,32'h88, 1'b1,32'h200,1'b0, 1'b1,32'h200,32'h88);
    tbl[20] = mk(1'b0,1'b1,32'hFFFF_FFFC,1'b0,32'h0, 1'b0,32'h0,1'b0, 1'b0,32'h0,32'h0);
    tbl[21] = mk(1'b0,1'b0,32'h0,1'b1,32'h99, 1'b1,32'hFFFF_FFFC,1'b0, 1'b1,32'hFFFF_FFFC,32'h99);
    tbl[22] = mk(1'b0,1'b0,32'h0,1'b0,32'h0,  1'b1,32'h0,1'b0,  1'b1,32'hFFFF_FFFC,32'h99);
    tbl[23] = mk(1'b0,1'b1,ODD_TGT,1'b1,32'hAA, 1'b1,32'h0,1'b1, 1'b0,32'h0,32'h0);
    tbl[24] = mk(1'b0,1'b0,32'h0,1'b1,32'hBB, 1'b1,32'h100,1'b0, 1'b1,32'h100,32'hBB);
    tbl[25] = mk(1'b0,1'b0,32'h0,1'b0,32'h0,  1'b1,32'h104,1'b0, 1'b1,32'h100,32'hBB);
    tbl[26] = mk(1'b1,1'b0,32'h0,1'b1,32'hCC, 1'b1,32'h104,1'b1, 1'b1,32'h100,32'hBB);
    tbl[27] = mk(1'b1,1'b1,32'h300,1'b0,32'h0, 1'b0,32'h0,1'b0, 1'b0,32'h0,32'h0);
    tbl[28] = mk(1'b0,1'b0,32'h0,1'b1,32'hDD, 1'b1,32'h300,1'b0, 1'b1,32'h300,32'hDD);
    tbl[29] = mk(1'b1,1'b0,32'h0,1'b0,32'h0,  1'b0,32'h0,1'b0,  1'b1,32'h300,32'hDD);

    // Reset state, with stallF low so the request gating by reset is visible.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req", 32'(imem.imem_req), 32'd0);
    chk("reset_valid", 32'(fe_valid), 32'd0);
    chk("reset_busy", 32'(fe_busy), 32'd0);
    chk("reset_pc", PC_fe_output, 32'd0);
    chk("reset_pcinc", PCInc_fe_output, 32'd0);
    chk("reset_instr", Instr_fe_output, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) apply_row(tbl[i], i);

    // Reset asserted while a request is outstanding.
    stallF = 1'b0; clrBU = 1'b0; imem.imem_ack = 1'b0;
    #1;
    chk("midwait_req_before", 32'(imem.imem_req), 32'd1);
    chk("midwait_addr_before", imem.imem_addr, 32'h304);
    @(posedge clk); #1;
    chk("midwait_busy", 32'(fe_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midwait_req_reset", 32'(imem.imem_req), 32'd0);
    chk("midwait_busy_reset", 32'(fe_busy), 32'd0);
    chk("midwait_valid_reset", 32'(fe_valid), 32'd0);
    chk("midwait_pc_reset", PC_fe_output, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 11) == 0);
      tg = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
`ifdef FETCH_MISALIGN_TRAP_EN
      tg = tg & 32'hFFFF_FFFC;
`endif
      rq = m_req(st, cl);
      ad = m_pend ? m_pend_addr : m_pc;
      ak = rq && ($urandom_range(0, 1) == 1);
      rd = $urandom();
      stallF = st; clrBU = cl; branch_target = tg;
      imem.imem_ack = ak; imem.imem_rdata = rd;
      #1;
      chk("rnd_req", 32'(imem.imem_req), 32'(rq));
      if (rq) chk("rnd_addr", imem.imem_addr, ad);
      chk("rnd_busy", 32'(fe_busy), 32'(m_pend));
      @(posedge clk); #1;
      m_edge(st, cl, tg, ak, rd);
      chk("rnd_valid", 32'(fe_valid), 32'(m_ovalid));
      chk("rnd_pc", PC_fe_output, m_opc);
      chk("rnd_pcinc", PCInc_fe_output, m_oinc);
      chk("rnd_instr", Instr_fe_output, m_oins);
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect traps until an aligned redirect arrives.
    stallF = 1'b0; clrBU = 1'b1; branch_target = 32'h102; imem.imem_ack = 1'b0;
    @(posedge clk); #1;
    clrBU = 1'b0;
    chk("fault_flag", 32'(misalign_fault), 32'd1);
    chk("fault_valid", 32'(fe_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fault_req", 32'(imem.imem_req), 32'd0);
      @(posedge clk); #1;
    end
    clrBU = 1'b1; branch_target = 32'h400;
    @(posedge clk); #1;
    clrBU = 1'b0;
    chk("fault_clear", 32'(misalign_fault), 32'd0);
    #1;
    chk("fault_resume_req", 32'(imem.imem_req), 32'd1);
    chk("fault_resume_addr", imem.imem_addr, 32'h400);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
